// File: rtl/mux16_pkg.sv
// Shared constants and types for the 16-bit mux capture FIFO.
// Optional feature macro: MUX16_SEL_TAG_EN (stores the mux select bit with each word).
package mux16_pkg;

    localparam int MUX_WIDTH  = 16;
    localparam int FIFO_DEPTH = 4;

`ifdef MUX16_SEL_TAG_EN
    localparam int SEL_TAG_W = 1;
`else
    localparam int SEL_TAG_W = 0;
`endif

    typedef logic [MUX_WIDTH-1:0] word_t;

    // One stored FIFO entry: the captured word plus, when enabled, its select tag.
    typedef struct packed {
`ifdef MUX16_SEL_TAG_EN
        logic  sel;
`endif
        word_t data;
    } entry_t;

endpackage

// File: rtl/mux16_fifo_mem.sv
// DEPTH x WIDTH storage array: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; occupancy tracking lives in the controller.
module mux16_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the incoming entry into the addressed slot on an accepted push.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/mux16_capture_fifo.sv
// First-word-fall-through capture FIFO behind the 16-bit 2:1 mux.
// Words are pushed with an in_valid/in_ready handshake and drained with
// out_valid/out_ready. Full/empty come only from the occupancy counter, so
// the pointers are free to wrap. A full FIFO refuses a push even when a pop
// happens on the same edge.
// Optional feature macro: MUX16_SEL_TAG_EN adds in_sel/out_sel tag ports.
module mux16_capture_fifo
    import mux16_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef MUX16_SEL_TAG_EN
    input  logic                     in_sel,
    output logic                     out_sel,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MEM_W = WIDTH + SEL_TAG_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [MEM_W-1:0] w_wr_entry;
    logic [MEM_W-1:0] w_rd_entry;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == {CNT_W{1'b0}});
    assign in_ready  = !rst && !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign count     = r_count;

`ifdef MUX16_SEL_TAG_EN
    assign w_wr_entry = {in_sel, in_data};
`else
    assign w_wr_entry = in_data;
`endif

    mux16_fifo_mem #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_entry)
    );

    // Advance write/read pointers on accepted pushes/pops; reset discards all entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Track occupancy; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {CNT_W{1'b0}};
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Present the head word, forced to zero while the FIFO is empty.
    always_comb begin
        out_data = {WIDTH{1'b0}};
        if (!w_empty) begin
            out_data = w_rd_entry[WIDTH-1:0];
        end else begin
            out_data = {WIDTH{1'b0}};
        end
    end

`ifdef MUX16_SEL_TAG_EN
    // Present the head tag, forced to zero while empty or in reset.
    always_comb begin
        out_sel = 1'b0;
        if (!rst && !w_empty) begin
            out_sel = w_rd_entry[WIDTH];
        end else begin
            out_sel = 1'b0;
        end
    end
`endif

endmodule
